// File: rtl/id_ex_issue_fifo_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_issue_fifo_pkg
// Shared pipeline definitions used by the ID/EX issue FIFO: the decoded
// ID->EX pack, its control sub-fields, and the default buffer depth.
// No ports (package).
// -----------------------------------------------------------------------------
package id_ex_issue_fifo_pkg;

    localparam int ID_EX_FIFO_DEPTH = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // All-zero control fields describe a bubble (no side effects in EX).
    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
    } type_ID_EX_Ctrl;

    typedef struct packed {
        type_ID_EX_Ctrl ctrl;
        logic [4:0]     rd;
        logic [31:0]    op_a;
        logic [31:0]    op_b;
    } type_ID_EX_Pack;

endpackage

// File: rtl/id_ex_issue_fifo_if.sv
// -----------------------------------------------------------------------------
// id_ex_issue_fifo_if
// Handshake bundle between ID (producer), EX (consumer) and the issue FIFO.
//   push/wData/full : ID write side
//   pop/rData/empty : EX read side (rData is the head, valid while !empty)
//   count           : stored entries, 0..DEPTH
// Modports: master = pipeline stages driving push/pop, slave = the FIFO.
// -----------------------------------------------------------------------------
interface id_ex_issue_fifo_if
    import id_ex_issue_fifo_pkg::*;
#(
    parameter int DEPTH  = ID_EX_FIFO_DEPTH,
    parameter int PACK_W = $bits(type_ID_EX_Pack)
);
    logic                     push;
    logic [PACK_W-1:0]        wData;
    logic                     full;
    logic                     pop;
    logic [PACK_W-1:0]        rData;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output push, wData, pop,
        input  full, rData, empty, count
    );

    modport slave (
        input  push, wData, pop,
        output full, rData, empty, count
    );
endinterface

// File: rtl/id_ex_issue_fifo_mem.sv
// -----------------------------------------------------------------------------
// id_ex_issue_fifo_mem  (fifo_mem)
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port, no reset.
//   clk        : write clock
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address
//   o_rd_data  : read data (combinational from the array)
// -----------------------------------------------------------------------------
module id_ex_issue_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);
    // NOTE: storage is deliberately not reset; stale contents are never
    // observable because the reader gates the output with its empty flag.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/id_ex_issue_fifo.sv
// -----------------------------------------------------------------------------
// id_ex_issue_fifo
// Decoupling buffer between ID and EX. ID pushes decoded packs, EX reads the
// head combinationally and pops it in the same cycle.
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-low reset (same effect as flush, overrides all)
//   flush : discard every entry at the next edge
//   bus   : slave side of id_ex_issue_fifo_if (push/wData/full,
//           pop/rData/empty, count)
// Optional feature macro: ID_EX_FIFO_BYPASS_EN -- when the buffer is empty and
// push and pop arrive together (no flush), wData is forwarded to rData in the
// same cycle and is not stored.
// -----------------------------------------------------------------------------
module id_ex_issue_fifo
    import id_ex_issue_fifo_pkg::*;
#(
    parameter int DEPTH  = ID_EX_FIFO_DEPTH,
    parameter int PACK_W = $bits(type_ID_EX_Pack)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_ex_issue_fifo_if.slave   bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;

    // Pointers carry one extra MSB (wrap bit) to tell full from empty.
    logic [AW:0]       r_rptr;
    logic [AW:0]       r_wptr;

    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic              w_wr_en;
    logic [PACK_W-1:0] w_mem_rdata;
    logic [PACK_W-1:0] w_rdata;

    assign w_empty = (r_rptr == r_wptr);
    assign w_full  = (r_rptr[AW-1:0] == r_wptr[AW-1:0]) && (r_rptr[AW] != r_wptr[AW]);

`ifdef ID_EX_FIFO_BYPASS_EN
    assign w_bypass = w_empty && bus.push && bus.pop && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop in the same cycle frees the head slot, so a full buffer still
    // takes the push. A bypassed entry is consumed directly and never stored.
    assign w_push_acc = bus.push && (!w_full || bus.pop) && !w_bypass && !flush;
    assign w_pop_acc  = bus.pop && !w_empty;
    assign w_wr_en    = w_push_acc && rst;

    id_ex_issue_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PACK_W)
    ) u_fifo_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_data (bus.wData),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_data (w_mem_rdata)
    );

    // Reset and flush share one clearing path; reset is sampled at the edge.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_rptr <= '0;
            r_wptr <= '0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Head is gated to all-zero when nothing is valid so EX sees a bubble.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch forms.
        w_rdata = '0;
        if (w_bypass) begin
            w_rdata = bus.wData;
        end else if (!w_empty) begin
            w_rdata = w_mem_rdata;
        end
    end

    assign bus.rData = w_rdata;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.count = r_wptr - r_rptr;
endmodule

// File: tb/tb_id_ex_issue_fifo.sv
// -----------------------------------------------------------------------------
// tb_id_ex_issue_fifo
// Self-checking bench for id_ex_issue_fifo: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_id_ex_issue_fifo;
    import id_ex_issue_fifo_pkg::*;

    localparam int DEPTH  = ID_EX_FIFO_DEPTH;
    localparam int PACK_W = $bits(type_ID_EX_Pack);

`ifdef ID_EX_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef logic [PACK_W-1:0] data_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    id_ex_issue_fifo_if #(.DEPTH(DEPTH), .PACK_W(PACK_W)) bus ();

    id_ex_issue_fifo #(
        .DEPTH  (DEPTH),
        .PACK_W (PACK_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_mis = 0;
    data_t model_q[$];

    function automatic data_t val(input logic [31:0] v);
        return data_t'(v);
    endfunction

    function automatic data_t rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PACK_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model just
    // before the edge, then advance the model by the rules of the buffer.
    task automatic cycle(input string tag, input logic p, input data_t d,
                         input logic q, input logic f, input logic r);
        int    sz;
        bit    byp;
        bit    do_pop;
        bit    do_push;
        data_t exp_r;
        bus.push  = p;
        bus.wData = d;
        bus.pop   = q;
        flush     = f;
        rst       = r;
        @(negedge clk);
        sz    = model_q.size();
        byp   = BYPASS && (sz == 0) && p && q && !f;
        exp_r = byp ? d : ((sz > 0) ? model_q[0] : '0);
        check({tag, "/rData"}, 128'(bus.rData), 128'(exp_r));
        check({tag, "/count"}, 128'(bus.count), 128'(sz));
        check({tag, "/empty"}, 128'(bus.empty), 128'(sz == 0));
        check({tag, "/full"},  128'(bus.full),  128'(sz == DEPTH));
        @(posedge clk);
        if (!r || f) begin
            model_q.delete();
        end else if (!byp) begin
            do_pop  = q && (sz > 0);
            do_push = p && ((sz < DEPTH) || q);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
    endtask

    data_t drain_exp [4];

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.wData = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles while ID keeps pushing.
        cycle("rst_hold0", 1'b1, val(32'hA5A5_A5A5), 1'b0, 1'b0, 1'b0);
        cycle("rst_hold1", 1'b1, val(32'hA5A5_A5A5), 1'b0, 1'b0, 1'b0);
        check("rst_empty", 128'(bus.empty), 128'(1));
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_rdata", 128'(bus.rData), 128'(0));
        cycle("first_push", 1'b1, val(32'h11), 1'b0, 1'b0, 1'b1);
        check("first_push_vis", 128'(bus.rData), 128'(32'h11));
        cycle("first_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, val(i), 1'b0, 1'b0, 1'b1);
        check("fill_full",  128'(bus.full),  128'(1));
        check("fill_count", 128'(bus.count), 128'(4));
        cycle("overflow", 1'b1, val(32'h5), 1'b0, 1'b0, 1'b1);
        check("overflow_count", 128'(bus.count), 128'(4));
        for (int i = 1; i <= 4; i++) begin
            check("drain_head", 128'(bus.rData), 128'(i));
            cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        end
        check("drain_empty", 128'(bus.empty), 128'(1));
        check("drain_rdata", 128'(bus.rData), 128'(0));

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) cycle("refill", 1'b1, val(i), 1'b0, 1'b0, 1'b1);
        check("fullpp_head", 128'(bus.rData), 128'(1));
        cycle("full_pushpop", 1'b1, val(32'h9), 1'b1, 1'b0, 1'b1);
        check("fullpp_count", 128'(bus.count), 128'(4));
        drain_exp[0] = val(2); drain_exp[1] = val(3); drain_exp[2] = val(4); drain_exp[3] = val(9);
        for (int i = 0; i < 4; i++) begin
            check("fullpp_drain", 128'(bus.rData), 128'(drain_exp[i]));
            cycle("fullpp_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        end

        // Wrap-around: push one, pop one, ten times.
        for (int i = 0; i < 10; i++) begin
            cycle("wrap_push", 1'b1, val(32'h20 + i), 1'b0, 1'b0, 1'b1);
            check("wrap_head", 128'(bus.rData), 128'(32'h20 + i));
            cycle("wrap_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        end
        check("wrap_empty", 128'(bus.empty), 128'(1));

        // Flush with count=3 plus concurrent push and pop.
        for (int i = 0; i < 3; i++) cycle("pre_flush", 1'b1, val(32'h61 + i), 1'b0, 1'b0, 1'b1);
        check("pre_flush_count", 128'(bus.count), 128'(3));
        cycle("flush", 1'b1, val(32'h7), 1'b1, 1'b1, 1'b1);
        check("flush_empty", 128'(bus.empty), 128'(1));
        check("flush_count", 128'(bus.count), 128'(0));
        check("flush_rdata", 128'(bus.rData), 128'(0));
        cycle("post_flush", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Push and pop together on an empty buffer.
        cycle("empty_pushpop", 1'b1, val(32'h33), 1'b1, 1'b0, 1'b1);
`ifdef ID_EX_FIFO_BYPASS_EN
        check("bypass_empty", 128'(bus.empty), 128'(1));
        check("bypass_count", 128'(bus.count), 128'(0));
`else
        check("nobypass_rdata", 128'(bus.rData), 128'(32'h33));
        check("nobypass_count", 128'(bus.count), 128'(1));
`endif
        cycle("empty_pushpop_pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Reset asserted mid-stream with push and pop in flight.
        cycle("mid_push0", 1'b1, val(32'h44), 1'b0, 1'b0, 1'b1);
        cycle("mid_push1", 1'b1, val(32'h45), 1'b0, 1'b0, 1'b1);
        cycle("mid_rst", 1'b1, val(32'h46), 1'b1, 1'b0, 1'b0);
        check("mid_rst_empty", 128'(bus.empty), 128'(1));
        check("mid_rst_rdata", 128'(bus.rData), 128'(0));

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 3) != 0),
                  rand_data(),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 63) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
